kernel_cmd_sequencer: RTL and testbench
=======================================

Name: kernel_cmd_sequencer

Overview:
- Sits between the AXI-lite kernel register block and the compute engine.
- Consumes the command byte and its one-cycle "new" strobe plus the argument words, and sequences the engine through start, run, abort, done and error.
- Returns a status word array to the register block for host readback.
- Adds a cycle counter, a timeout watchdog, a completion counter and a level interrupt.

Parameters:
ARG_NUM, 32, number of argument/status words (power of two, >=8)
WORD_W, 32, width of each argument/status word

Ports:
clk  in  1  clock
rst  in  1  asynchronous reset, active-high
kernel_command  in  8  command byte (arg word 0, low byte)
kernel_command_new  in  1  one-cycle strobe, command byte valid
kernel_engine_arg  in  ARG_NUM x WORD_W  argument words
eng_start  out  1  one-cycle engine start pulse
eng_abort  out  1  level abort request to engine
eng_base  out  WORD_W  latched arg[1], job base address
eng_len  out  WORD_W  latched arg[2], job length
eng_done  in  1  one-cycle engine completion pulse
eng_error  in  1  engine error flag, sampled only with eng_done
kernel_engine_status  out  ARG_NUM x WORD_W  status words to register block
irq  out  1  level interrupt

Behaviour:
- Reset (async, rst=1): state=IDLE; all outputs 0; all counters 0; latched args 0.
- Command codes:
  - 0x01 START
  - 0x02 ABORT
  - 0x03 CLEAR
  - Any other code with the strobe is ignored.
- A command is acted on only in the cycle kernel_command_new=1.
- States (status encoding in brackets): IDLE(0), START(1), RUN(2), ABORT(3), DONE(4), ERROR(5).
- IDLE:
  - START with arg[2]!=0: latch arg[1] to eng_base, arg[2] to eng_len, arg[3] to timeout_lim; go to START.
  - START with arg[2]==0: go directly to DONE; no eng_start; done_cnt increments.
  - ABORT or CLEAR: ignored.
- START:
  - eng_start=1 for exactly this cycle; cyc_cnt cleared to 0; go to RUN.
  - Latency: strobe at cycle N, eng_start high at N+1, RUN at N+2.
- RUN:
  - cyc_cnt increments each cycle, saturating at all-ones.
  - Priority order:
    1. eng_done: go to ERROR (err_code=1) if eng_error, else DONE.
    2. ABORT command: go to ABORT (err_code=2).
    3. timeout_lim!=0 and cyc_cnt==timeout_lim-1: go to ABORT (err_code=3).
    4. START command: ignored; ign_cnt increments.
  - timeout_lim==0 disables the watchdog.
- ABORT:
  - eng_abort=1 (level) until eng_done arrives; then go to ERROR and keep the stored err_code.
  - cyc_cnt keeps counting.
  - Further commands are ignored; ign_cnt increments.
- DONE:
  - Entry: done_cnt increments (wraps).
  - irq=1.
  - CLEAR: go to IDLE.
  - START: treated as in IDLE (re-latch args, restart).
- ERROR:
  - irq=1.
  - Only CLEAR leaves it: go to IDLE and clear err_code.
  - START: ignored; ign_cnt increments.
- eng_done outside RUN/ABORT: ignored (stale completion).
- irq is a registered decode: 1 in DONE/ERROR, 0 otherwise.
- Status words, registered, reflect state one cycle late:
  - [0]: bits[2:0]=state, bit[8]=irq, bits[23:16]=err_code
  - [1]: cyc_cnt
  - [2]: done_cnt
  - [3]: ign_cnt (8-bit, saturating, zero-extended)
  - [4]: eng_base
  - [5]: eng_len
  - All other words read 0.
- Reset mid-operation: all state returns to reset values immediately; eng_abort drops; no completion is counted.

Test Plan:
- Reset; arg[1]=0x1000, arg[2]=16, arg[3]=0, START. Expect eng_start high exactly 1 cycle after the strobe, eng_base=0x1000, eng_len=16. Engine gives eng_done after 10 RUN cycles. Expect state=DONE, irq=1, status[1]=10, status[2]=1. Then CLEAR: state=IDLE, irq=0.
- arg[3]=5, engine never completes. Expect ABORT after 5 RUN cycles with eng_abort=1. eng_done 3 cycles later: expect ERROR, err_code=3, irq=1. START in ERROR: ignored, status[3]=1.
- ABORT command 4 cycles into RUN. Expect eng_abort level until eng_done, then ERROR with err_code=2.
- eng_done with eng_error=1 in RUN: expect ERROR, err_code=1. Simultaneous eng_done and ABORT strobe in RUN: eng_done wins, giving DONE.
- START with arg[2]=0: expect no eng_start pulse, state goes directly to DONE, status[2] increments.
- rst asserted during ABORT: expect all outputs 0 and state IDLE in the same cycle. A later eng_done is ignored.

Source files
------------

// File: rtl/kernel_cmd_sequencer.sv
// ---------------------------------------------------------------------------
// kernel_cmd_sequencer
//
// Purpose:
//   Sits between the AXI-lite kernel register block and the compute engine.
//   Decodes the command byte (qualified by a one-cycle "new" strobe) and
//   sequences the engine through START -> RUN -> DONE / ABORT / ERROR.
//   Keeps a run cycle counter with a timeout watchdog, a completion counter
//   and an ignored-command counter, drives a level interrupt, and returns a
//   status word array for host readback.
//
// Ports:
//   clk                   clock
//   rst                   asynchronous reset, active-high
//   kernel_command        command byte (0x01 START, 0x02 ABORT, 0x03 CLEAR)
//   kernel_command_new    one-cycle strobe qualifying kernel_command
//   kernel_engine_arg     ARG_NUM x WORD_W argument words, word i at
//                         [i*WORD_W +: WORD_W]; [1]=base, [2]=len, [3]=timeout
//   eng_start             one-cycle engine start pulse
//   eng_abort             level abort request, held until eng_done
//   eng_base / eng_len    job base address / length latched at START
//   eng_done              one-cycle engine completion pulse
//   eng_error             engine error flag, meaningful only with eng_done
//   kernel_engine_status  ARG_NUM x WORD_W status words (same packing)
//   irq                   level interrupt, high in DONE and ERROR
// ---------------------------------------------------------------------------
module kernel_cmd_sequencer #(
  parameter int ARG_NUM = 32,
  parameter int WORD_W  = 32
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [7:0]                  kernel_command,
  input  logic                        kernel_command_new,
  input  logic [ARG_NUM*WORD_W-1:0]   kernel_engine_arg,
  output logic                        eng_start,
  output logic                        eng_abort,
  output logic [WORD_W-1:0]           eng_base,
  output logic [WORD_W-1:0]           eng_len,
  input  logic                        eng_done,
  input  logic                        eng_error,
  output logic [ARG_NUM*WORD_W-1:0]   kernel_engine_status,
  output logic                        irq
);

  localparam logic [7:0]        CMD_START = 8'h01;
  localparam logic [7:0]        CMD_ABORT = 8'h02;
  localparam logic [7:0]        CMD_CLEAR = 8'h03;
  localparam logic [WORD_W-1:0] ONE_W     = {{(WORD_W-1){1'b0}}, 1'b1};
  localparam int                STAT_USED = 6;

  localparam logic [7:0] ERR_ENGINE  = 8'd1;
  localparam logic [7:0] ERR_ABORT   = 8'd2;
  localparam logic [7:0] ERR_TIMEOUT = 8'd3;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_RUN   = 3'd2,
    ST_ABORT = 3'd3,
    ST_DONE  = 3'd4,
    ST_ERROR = 3'd5
  } state_t;

  state_t            state_reg;
  logic [WORD_W-1:0] cyc_cnt_reg;
  logic [WORD_W-1:0] done_cnt_reg;
  logic [WORD_W-1:0] timeout_lim_reg;
  logic [7:0]        ign_cnt_reg;
  logic [7:0]        err_code_reg;

  // Argument words consumed by the sequencer
  logic [WORD_W-1:0] arg_base;
  logic [WORD_W-1:0] arg_len;
  logic [WORD_W-1:0] arg_lim;
  assign arg_base = kernel_engine_arg[1*WORD_W +: WORD_W];
  assign arg_len  = kernel_engine_arg[2*WORD_W +: WORD_W];
  assign arg_lim  = kernel_engine_arg[3*WORD_W +: WORD_W];

  // Word 0 travels on its own port and words above 3 belong to other
  // consumers of the register block.
  logic unused_arg_bits;
  assign unused_arg_bits = ^{kernel_engine_arg[WORD_W-1:0],
                             kernel_engine_arg[ARG_NUM*WORD_W-1:4*WORD_W]};

  // Command decode, qualified by the strobe
  logic cmd_start;
  logic cmd_abort;
  logic cmd_clear;
  logic cmd_any;
  assign cmd_start = kernel_command_new && (kernel_command == CMD_START);
  assign cmd_abort = kernel_command_new && (kernel_command == CMD_ABORT);
  assign cmd_clear = kernel_command_new && (kernel_command == CMD_CLEAR);
  assign cmd_any   = cmd_start || cmd_abort || cmd_clear;

  // Saturating increments
  logic [WORD_W-1:0] cyc_cnt_inc;
  logic [7:0]        ign_cnt_inc;
  assign cyc_cnt_inc = (&cyc_cnt_reg) ? cyc_cnt_reg : cyc_cnt_reg + ONE_W;
  assign ign_cnt_inc = (&ign_cnt_reg) ? ign_cnt_reg : ign_cnt_reg + 8'd1;

  // Watchdog fires on the last allowed RUN cycle so the job spends exactly
  // timeout_lim cycles in RUN; a zero limit disables it.
  logic timeout_hit;
  assign timeout_hit = (timeout_lim_reg != '0) &&
                       (cyc_cnt_reg == timeout_lim_reg - ONE_W);

  // -------------------------------------------------------------------------
  // Sequencer FSM. irq and eng_abort are updated on every transition so they
  // are registered yet aligned with state_reg.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg       <= ST_IDLE;
      eng_start       <= 1'b0;
      eng_abort       <= 1'b0;
      eng_base        <= '0;
      eng_len         <= '0;
      irq             <= 1'b0;
      cyc_cnt_reg     <= '0;
      done_cnt_reg    <= '0;
      timeout_lim_reg <= '0;
      ign_cnt_reg     <= '0;
      err_code_reg    <= '0;
    end else begin
      eng_start <= 1'b0;
      case (state_reg)
        // DONE accepts START exactly like IDLE; only DONE reacts to CLEAR.
        ST_IDLE, ST_DONE: begin
          if (cmd_start) begin
            if (arg_len != '0) begin
              eng_base        <= arg_base;
              eng_len         <= arg_len;
              timeout_lim_reg <= arg_lim;
              eng_start       <= 1'b1;
              irq             <= 1'b0;
              state_reg       <= ST_START;
            end else begin
              // Empty job completes immediately without touching the engine
              done_cnt_reg <= done_cnt_reg + ONE_W;
              irq          <= 1'b1;
              state_reg    <= ST_DONE;
            end
          end else if (cmd_clear && (state_reg == ST_DONE)) begin
            irq       <= 1'b0;
            state_reg <= ST_IDLE;
          end
        end

        ST_START: begin
          cyc_cnt_reg <= '0;
          state_reg   <= ST_RUN;
        end

        ST_RUN: begin
          cyc_cnt_reg <= cyc_cnt_inc;
          if (eng_done) begin
            irq <= 1'b1;
            if (eng_error) begin
              err_code_reg <= ERR_ENGINE;
              state_reg    <= ST_ERROR;
            end else begin
              done_cnt_reg <= done_cnt_reg + ONE_W;
              state_reg    <= ST_DONE;
            end
          end else if (cmd_abort) begin
            err_code_reg <= ERR_ABORT;
            eng_abort    <= 1'b1;
            state_reg    <= ST_ABORT;
          end else if (timeout_hit) begin
            err_code_reg <= ERR_TIMEOUT;
            eng_abort    <= 1'b1;
            state_reg    <= ST_ABORT;
          end else if (cmd_start) begin
            ign_cnt_reg <= ign_cnt_inc;
          end
        end

        // Wait for the engine to acknowledge the abort with eng_done; the
        // err_code recorded on entry is kept.
        ST_ABORT: begin
          cyc_cnt_reg <= cyc_cnt_inc;
          if (cmd_any) begin
            ign_cnt_reg <= ign_cnt_inc;
          end
          if (eng_done) begin
            eng_abort <= 1'b0;
            irq       <= 1'b1;
            state_reg <= ST_ERROR;
          end
        end

        ST_ERROR: begin
          if (cmd_clear) begin
            err_code_reg <= '0;
            irq          <= 1'b0;
            state_reg    <= ST_IDLE;
          end else if (cmd_start) begin
            ign_cnt_reg <= ign_cnt_inc;
          end
        end

        default: begin
          eng_abort <= 1'b0;
          irq       <= 1'b0;
          state_reg <= ST_IDLE;
        end
      endcase
    end
  end

  // -------------------------------------------------------------------------
  // Status words: a registered snapshot, one cycle behind the FSM.
  // -------------------------------------------------------------------------
  logic [WORD_W-1:0] status_next [STAT_USED];
  logic [WORD_W-1:0] status_reg  [STAT_USED];

  always_comb begin
    for (int i = 0; i < STAT_USED; i++) begin
      status_next[i] = '0;
    end
    status_next[0][2:0]   = state_reg;
    status_next[0][8]     = irq;
    status_next[0][23:16] = err_code_reg;
    status_next[1]        = cyc_cnt_reg;
    status_next[2]        = done_cnt_reg;
    status_next[3][7:0]   = ign_cnt_reg;
    status_next[4]        = eng_base;
    status_next[5]        = eng_len;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < STAT_USED; i++) begin
        status_reg[i] <= '0;
      end
    end else begin
      for (int i = 0; i < STAT_USED; i++) begin
        status_reg[i] <= status_next[i];
      end
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < ARG_NUM; gi++) begin : g_status
      if (gi < STAT_USED) begin : g_used
        assign kernel_engine_status[gi*WORD_W +: WORD_W] = status_reg[gi];
      end else begin : g_zero
        assign kernel_engine_status[gi*WORD_W +: WORD_W] = '0;
      end
    end
  endgenerate

endmodule

// File: tb/tb_kernel_cmd_sequencer.sv
// ---------------------------------------------------------------------------
// tb_kernel_cmd_sequencer
//
// Purpose:
//   Self-checking bench for kernel_cmd_sequencer. The stimulus process plays
//   both host and engine, job by job. Before each job it derives the
//   expected observable outcome (start pulse timing and arguments, abort
//   window, final status snapshot) from the job parameters with plain
//   arithmetic and pushes it into queues; an independent monitor pops and
//   compares whenever the DUT presents the corresponding event.
// ---------------------------------------------------------------------------
module tb_kernel_cmd_sequencer;

  localparam int ARG_NUM = 32;
  localparam int WORD_W  = 32;

  logic                      clk;
  logic                      rst;
  logic [7:0]                kernel_command;
  logic                      kernel_command_new;
  logic [ARG_NUM*WORD_W-1:0] kernel_engine_arg;
  logic                      eng_start;
  logic                      eng_abort;
  logic [WORD_W-1:0]         eng_base;
  logic [WORD_W-1:0]         eng_len;
  logic                      eng_done;
  logic                      eng_error;
  logic [ARG_NUM*WORD_W-1:0] kernel_engine_status;
  logic                      irq;

  kernel_cmd_sequencer #(.ARG_NUM(ARG_NUM), .WORD_W(WORD_W)) dut (
    .clk                  (clk),
    .rst                  (rst),
    .kernel_command       (kernel_command),
    .kernel_command_new   (kernel_command_new),
    .kernel_engine_arg    (kernel_engine_arg),
    .eng_start            (eng_start),
    .eng_abort            (eng_abort),
    .eng_base             (eng_base),
    .eng_len              (eng_len),
    .eng_done             (eng_done),
    .eng_error            (eng_error),
    .kernel_engine_status (kernel_engine_status),
    .irq                  (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc_n = 0;
  always @(posedge clk) cyc_n <= cyc_n + 1;

  int tests = 0;
  int fails = 0;

  // Expected-event queues
  typedef struct packed { int cyc; logic [31:0] base; logic [31:0] len; } start_t;
  typedef struct packed { int rise; int len; } abort_t;
  typedef struct packed {
    logic [31:0] w0; logic [31:0] w1; logic [31:0] w2;
    logic [31:0] w3; logic [31:0] w4; logic [31:0] w5;
  } snap_t;

  start_t start_q[$];
  abort_t abort_q[$];
  snap_t  snap_q[$];

  // Reference model state
  logic [31:0] m_done, m_cyc, m_base, m_len;
  int          m_ign;
  bit          m_in_done;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, exp, cyc_n);
    end
  endtask

  function automatic logic [31:0] stat(input int i);
    return kernel_engine_status[i*WORD_W +: WORD_W];
  endfunction

  function automatic snap_t mk_snap(input int st, input int err);
    snap_t s;
    s.w0 = 32'(st) | 32'h100 | (32'(err) << 16);
    s.w1 = m_cyc;
    s.w2 = m_done;
    s.w3 = (m_ign > 255) ? 32'd255 : 32'(m_ign);
    s.w4 = m_base;
    s.w5 = m_len;
    return s;
  endfunction

  // ---------------------------------------------------------------- monitor
  logic prev_start = 1'b0;
  logic prev_abort = 1'b0;
  logic prev_s0    = 1'b0;
  int   ab_rise    = 0;
  int   ab_cnt     = 0;

  always @(negedge clk) begin
    if (prev_start) check("start_width", {31'b0, eng_start}, 32'd0);
    if (eng_start && !prev_start) begin
      if (start_q.size() == 0) begin
        tests++; fails++;
        $display("FAIL start_unexpected: eng_start=1 at cycle %0d, expected no pulse", cyc_n);
      end else begin
        check("start_cycle", cyc_n, start_q[0].cyc);
        check("eng_base", eng_base, start_q[0].base);
        check("eng_len", eng_len, start_q[0].len);
        void'(start_q.pop_front());
      end
    end

    if (eng_abort) begin
      if (!prev_abort) ab_rise <= cyc_n;
      ab_cnt <= prev_abort ? ab_cnt + 1 : 1;
    end else if (prev_abort) begin
      if (abort_q.size() == 0) begin
        tests++; fails++;
        $display("FAIL abort_unexpected: eng_abort window of %0d cycles, expected none", ab_cnt);
      end else begin
        check("abort_rise", ab_rise, abort_q[0].rise);
        check("abort_len", ab_cnt, abort_q[0].len);
        void'(abort_q.pop_front());
      end
    end

    if (kernel_engine_status[8] && !prev_s0) begin
      if (snap_q.size() == 0) begin
        tests++; fails++;
        $display("FAIL snap_unexpected: status irq bit rose at cycle %0d, expected none", cyc_n);
      end else begin
        check("snap_irq", {31'b0, irq}, 32'd1);
        check("snap_w0_state_err", stat(0), snap_q[0].w0);
        check("snap_w1_cyc_cnt", stat(1), snap_q[0].w1);
        check("snap_w2_done_cnt", stat(2), snap_q[0].w2);
        check("snap_w3_ign_cnt", stat(3), snap_q[0].w3);
        check("snap_w4_base", stat(4), snap_q[0].w4);
        check("snap_w5_len", stat(5), snap_q[0].w5);
        check("snap_unused_word", stat($urandom_range(6, ARG_NUM-1)), 32'd0);
        void'(snap_q.pop_front());
      end
    end

    prev_start <= eng_start;
    prev_abort <= eng_abort;
    prev_s0    <= kernel_engine_status[8];
  end

  // -------------------------------------------------------------- stimulus
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    kernel_command_new = 1'b0;
    kernel_command     = 8'h00;
    eng_done           = 1'b0;
    eng_error          = 1'b0;
  endtask

  task automatic send_cmd(input logic [7:0] code);
    kernel_command     = code;
    kernel_command_new = 1'b1;
    tick();
    kernel_command_new = 1'b0;
    kernel_command     = 8'h00;
  endtask

  task automatic set_args(input logic [31:0] base, input logic [31:0] len, input int lim);
    for (int i = 0; i < ARG_NUM; i++) kernel_engine_arg[i*WORD_W +: WORD_W] = $urandom;
    kernel_engine_arg[1*WORD_W +: WORD_W] = base;
    kernel_engine_arg[2*WORD_W +: WORD_W] = len;
    kernel_engine_arg[3*WORD_W +: WORD_W] = 32'(lim);
  endtask

  task automatic do_clear();
    send_cmd(8'h03);
    @(negedge clk);
    check("clear_irq", {31'b0, irq}, 32'd0);
    check("clear_abort", {31'b0, eng_abort}, 32'd0);
    tick();
    check("clear_status_w0", stat(0), 32'd0);
    m_in_done = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_eng_start"}, {31'b0, eng_start}, 32'd0);
    check({tag, "_eng_abort"}, {31'b0, eng_abort}, 32'd0);
    check({tag, "_irq"}, {31'b0, irq}, 32'd0);
    check({tag, "_eng_base"}, eng_base, 32'd0);
    check({tag, "_eng_len"}, eng_len, 32'd0);
    for (int i = 0; i < 6; i++) check({tag, "_status"}, stat(i), 32'd0);
  endtask

  // kind: 0 engine done (err_flag selects error), 1 ABORT command at RUN
  // cycle k, 2 watchdog timeout of lim, 3 zero-length job, 4 done and ABORT
  // together at RUN cycle k, 5 ABORT at RUN cycle k then reset d cycles in.
  // j: RUN cycle carrying an extra (ignored) START, 0 = none.
  // m: ABORT cycle carrying an extra (ignored) command, 0 = none.
  task automatic run_job(input int kind, input logic [31:0] base, input logic [31:0] len,
                         input int lim, input int k, input int d, input bit err_flag,
                         input int j, input int m, input bit stay, input int nstart);
    int s, rc, nrun, res_state, res_err;
    if (m_in_done && kind == 3) do_clear();
    set_args(base, len, lim);
    s = cyc_n;
    rc = s + 2;
    res_state = 4;
    res_err = 0;
    if (kind == 3) begin
      m_done = m_done + 1;
    end else begin
      m_base = base;
      m_len = len;
      start_q.push_back('{cyc: s + 1, base: base, len: len});
      if (j > 0) m_ign++;
      if (m > 0) m_ign++;
      case (kind)
        0: begin
          m_cyc = 32'(k);
          if (err_flag) begin res_state = 5; res_err = 1; end
          else m_done = m_done + 1;
        end
        4: begin m_cyc = 32'(k); m_done = m_done + 1; end
        1: begin
          m_cyc = 32'(k + d); res_state = 5; res_err = 2;
          abort_q.push_back('{rise: rc + k, len: d});
        end
        2: begin
          m_cyc = 32'(lim + d); res_state = 5; res_err = 3;
          abort_q.push_back('{rise: rc + lim, len: d});
        end
        default: abort_q.push_back('{rise: rc + k, len: d - 1});
      endcase
    end
    if (kind != 5) snap_q.push_back(mk_snap(res_state, res_err));
    $display("[TB] job kind=%0d base=0x%08h len=%0d lim=%0d k=%0d d=%0d err=%0d j=%0d m=%0d",
             kind, base, len, lim, k, d, err_flag, j, m);

    send_cmd(8'h01);
    if (kind != 3) begin
      tick();
      nrun = (kind == 2) ? lim : k;
      for (int i = 1; i <= nrun; i++) begin
        eng_done  = (kind == 0 || kind == 4) && (i == nrun);
        eng_error = (kind == 0) && err_flag && (i == nrun);
        kernel_command_new = (i == j) || ((kind == 1 || kind == 4 || kind == 5) && (i == nrun));
        kernel_command = (i == j) ? 8'h01 : 8'h02;
        tick();
      end
      idle_inputs();
      if (kind == 1 || kind == 2) begin
        for (int i = 1; i <= d; i++) begin
          eng_done = (i == d);
          kernel_command_new = (i == m);
          kernel_command = 8'($urandom_range(1, 3));
          tick();
        end
        idle_inputs();
      end
    end

    if (kind == 5) begin
      repeat (d - 1) tick();
      rst = 1'b1;
      #1;
      check_reset_outputs("rst_mid_abort");
      rst = 1'b0;
      m_done = 0; m_cyc = 0; m_base = 0; m_len = 0; m_ign = 0; m_in_done = 1'b0;
      tick();
      eng_done = 1'b1;
      tick();
      eng_done = 1'b0;
      tick();
      tick();
      check("stale_done_w0", stat(0), 32'd0);
      check("stale_done_w2", stat(2), 32'd0);
      check("stale_done_abort", {31'b0, eng_abort}, 32'd0);
      return;
    end

    repeat (3) tick();
    if (res_state == 5) begin
      repeat (nstart) begin
        send_cmd(8'h01);
        m_ign++;
      end
      tick();
      tick();
      check("error_ign_cnt", stat(3), 32'(m_ign));
      do_clear();
    end else if (stay) begin
      m_in_done = 1'b1;
    end else begin
      do_clear();
    end
  endtask

  initial begin
    int kind, k, lim, d, j, m, nrun;
    rst = 1'b1;
    idle_inputs();
    kernel_engine_arg = '0;
    m_done = 0; m_cyc = 0; m_base = 0; m_len = 0; m_ign = 0; m_in_done = 1'b0;
    #12;
    check_reset_outputs("reset");
    check("reset_unused_word", stat(ARG_NUM-1), 32'd0);
    rst = 1'b0;
    tick();

    // Unknown codes and ABORT/CLEAR in IDLE change nothing
    send_cmd(8'h07);
    send_cmd(8'h00);
    send_cmd(8'h02);
    send_cmd(8'h03);
    tick();
    tick();
    check("idle_ignore_w0", stat(0), 32'd0);
    check("idle_ignore_w3", stat(3), 32'd0);

    // Directed jobs
    run_job(0, 32'h1000, 32'd16, 0, 10, 0, 1'b0, 0, 0, 1'b0, 0);
    run_job(2, $urandom, 32'd64, 5, 0, 3, 1'b0, 0, 0, 1'b0, 1);
    run_job(1, $urandom, 32'd32, 0, 4, 3, 1'b0, 0, 0, 1'b0, 0);
    run_job(0, $urandom, 32'd8, 0, 6, 0, 1'b1, 0, 0, 1'b0, 0);
    run_job(4, $urandom, 32'd8, 0, 5, 0, 1'b0, 0, 0, 1'b0, 0);
    run_job(3, $urandom, 32'd0, 0, 0, 0, 1'b0, 0, 0, 1'b0, 0);
    run_job(5, $urandom, 32'd100, 0, 3, 4, 1'b0, 0, 0, 1'b0, 0);

    // Randomized jobs
    for (int n = 0; n < 40; n++) begin
      kind = $urandom_range(0, 5);
      k = $urandom_range(1, 12);
      if (kind == 2) lim = $urandom_range(1, 10);
      else lim = ($urandom_range(0, 1) == 0) ? 0 : $urandom_range(k, k + 8);
      d = (kind == 5) ? $urandom_range(2, 6) : $urandom_range(1, 6);
      nrun = (kind == 2) ? lim : k;
      j = (kind != 3 && kind != 5 && nrun > 1 && $urandom_range(0, 1) == 1)
          ? $urandom_range(1, nrun - 1) : 0;
      m = (kind == 1 || kind == 2) ? $urandom_range(0, d) : 0;
      run_job(kind, $urandom, (kind == 3) ? 32'd0 : 32'($urandom_range(1, 1000)), lim, k, d,
              1'($urandom_range(0, 1)), j, m, ($urandom_range(0, 2) == 0), $urandom_range(0, 2));
    end

    repeat (4) tick();
    check("start_q_empty", start_q.size(), 32'd0);
    check("abort_q_empty", abort_q.size(), 32'd0);
    check("snap_q_empty", snap_q.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, got no end of stimulus, expected completion");
    $fatal(1, "time limit");
  end

endmodule
